// File: rtl/feature_rd_sched.sv
// Read scheduler: pops one raster-ordered frame from the feature FWFT into a
// single-entry valid/ready output stage tagged with position and window flags.
module feature_rd_sched #(
  parameter  int IMG_W = 28,
  parameter  int IMG_H = 28,
  parameter  int K     = 3,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fifo_empty,
  input  logic [7:0]    in_feature,
  output logic          rd_en,
  output logic [7:0]    out_feature,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_eol,
  output logic          out_eof,
  output logic          win_valid,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    out_feature_q, out_feature_d;
  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          out_eol_q, out_eol_d;
  logic          out_eof_q, out_eof_d;
  logic          win_valid_q, win_valid_d;
  logic          done_q, done_d;

  logic accept;
  logic last_pop;

  assign accept   = out_valid_q && out_ready;
  assign last_pop = rd_en && (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      out_feature_q <= '0;
      out_valid_q   <= 1'b0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_eol_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      win_valid_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      out_feature_q <= out_feature_d;
      out_valid_q   <= out_valid_d;
      out_row_q     <= out_row_d;
      out_col_q     <= out_col_d;
      out_eol_q     <= out_eol_d;
      out_eof_q     <= out_eof_d;
      win_valid_q   <= win_valid_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)    state_d = S_STREAM;
      S_STREAM: if (last_pop) state_d = S_FLUSH;
      S_FLUSH:  if (accept)   state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // A pop is allowed only when the output stage is empty or being drained.
  always_comb begin
    busy  = (state_q != S_IDLE);
    rd_en = (state_q == S_STREAM) && !fifo_empty && (!out_valid_q || out_ready);
  end

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    out_feature_d = out_feature_q;
    out_valid_d   = out_valid_q;
    out_row_d     = out_row_q;
    out_col_d     = out_col_q;
    out_eol_d     = out_eol_q;
    out_eof_d     = out_eof_q;
    win_valid_d   = win_valid_q;
    done_d        = (state_q == S_FLUSH) && accept;

    if (state_q == S_IDLE) begin
      col_d = '0;
      row_d = '0;
    end

    if (rd_en) begin
      out_feature_d = in_feature;
      out_valid_d   = 1'b1;
      out_row_d     = row_q;
      out_col_d     = col_q;
      out_eol_d     = (col_q == COL_LAST);
      out_eof_d     = (col_q == COL_LAST) && (row_q == ROW_LAST);
      win_valid_d   = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_feature = out_feature_q;
  assign out_valid   = out_valid_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_eol     = out_eol_q;
  assign out_eof     = out_eof_q;
  assign win_valid   = win_valid_q;
  assign done        = done_q;

endmodule

// File: doc/feature_rd_sched.md
# feature_rd_sched

Read scheduler for the feature FWFT buffer in the convolution path. On `start`, it pops exactly one frame of `IMG_W*IMG_H` 8-bit features from the FWFT, in raster order. Each feature is registered into a single-entry output stage under a valid/ready handshake and tagged with row/column position, end-of-row, end-of-frame and conv-window-valid flags. It sits between the feature FWFT and the convolution MAC array, and is the only block that drives the FWFT `rd_en`.

## Interface
- `IMG_W`, 28, features per row (≥ `K`)
- `IMG_H`, 28, rows per frame (≥ `K`)
- `K`, 3, square kernel size; sets where `win_valid` asserts
- `CW` (local), `$clog2(IMG_W)`, column counter width; `RW` (local), `$clog2(IMG_H)`, row counter width

Ports:
- `clk`  in  1  single clock; everything is on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin one frame; sampled only in IDLE
- `fifo_empty`  in  1  FWFT empty; `in_feature` valid when low
- `in_feature`  in  8  FWFT head data
- `rd_en`  out  1  FWFT pop, combinational
- `out_feature`  out  8  registered feature
- `out_valid`  out  1  output stage holds data
- `out_ready`  in  1  downstream accepts
- `out_row`  out  RW  row of `out_feature`
- `out_col`  out  CW  column of `out_feature`
- `out_eol`  out  1  `out_col == IMG_W-1`
- `out_eof`  out  1  last feature of frame
- `win_valid`  out  1  `out_row ≥ K-1 && out_col ≥ K-1`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse when the frame's last feature is accepted

## Operation
- FSM states:
  - IDLE: `start` moves to STREAM; column and row counters clear to 0.
  - STREAM: pops features. The cycle that pops (row `IMG_H-1`, col `IMG_W-1`) moves to FLUSH.
  - FLUSH: no pops. When `out_valid && out_ready`, pulse `done` and return to IDLE.
- Pop rule: `rd_en = (state==STREAM) && !fifo_empty && (!out_valid || out_ready)`.
  - `rd_en` must never assert while `fifo_empty` is high.
  - `rd_en` must never assert outside STREAM.
- On a pop cycle:
  - `out_feature <= in_feature` and `out_valid <= 1`.
  - `out_row` and `out_col` are loaded with the current counter values.
  - `out_eol`, `out_eof` and `win_valid` are computed from those same counter values.
  - The column counter increments. At `IMG_W-1` it wraps to 0 and the row counter increments.
- Handshake:
  - If the output is accepted with no pop, `out_valid <= 0`.
  - If the output is accepted and a pop happens in the same cycle, `out_valid` stays 1 and the output registers load the new data (back-to-back, 1 feature/cycle).
  - While `out_valid && !out_ready`, all output registers hold and `rd_en` stays low.
- `start` while busy is ignored. A new frame's counters are always 0/0.
- Counters never exceed `IMG_W-1` / `IMG_H-1`. Row wrap at frame end is irrelevant because the FSM leaves STREAM.
- `out_eof` is 1 only on the (IMG_H-1, IMG_W-1) feature. `done` asserts the cycle after that feature's handshake.

## Timing
- Reset values:
  - state IDLE
  - `out_valid` 0, `out_feature` 0, `out_row` 0, `out_col` 0
  - `out_eol`, `out_eof`, `win_valid`, `done`, `busy` all 0
  - `rd_en` 0 as a consequence of IDLE
- Reset mid-frame: next cycle is IDLE with all outputs at reset values. Un-popped FWFT contents are not touched.
- `start` at edge N: `busy` is 1 from N+1. The first `rd_en` can occur in cycle N+1 if FWFT is non-empty.
- Latency: the pop at edge M gives `out_valid` = 1 after edge M (visible in cycle M+1).
- Throughput: with `out_ready` tied high and FWFT never empty, one feature per cycle. A frame takes `IMG_W*IMG_H` pop cycles, plus one FLUSH cycle, plus the `done` pulse.
- `done` and IDLE entry occur on the same edge. `busy` drops in the same cycle `done` is high. `start` in that cycle is sampled (IDLE), so frames can run back-to-back.
- `fifo_empty` high in STREAM: no pop. The output stage drains normally if `out_ready`.

## Test plan
- Basic frame, IMG_W=4, IMG_H=3, K=3:
  - Stimulus: FWFT preloaded with 0x00..0x0B, `out_ready`=1, `start` pulse.
  - Required: 12 consecutive outputs 0x00..0x0B.
  - `out_eol` on 0x03, 0x07 and 0x0B.
  - `out_eof` only on 0x0B.
  - `win_valid` only on (2,2)=0x0A and (2,3)=0x0B.
  - `done` one cycle after 0x0B is accepted.
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1 repeating.
  - Required: no `rd_en` while the output is held, no feature lost or duplicated, sequence still 0x00..0x0B.
- Starved FWFT:
  - Stimulus: `fifo_empty` high for 5 cycles mid-row (after 0x05).
  - Required: `rd_en`=0 throughout, `out_valid` drops after acceptance, stream resumes at 0x06 with `out_col`=2.
- Start while busy and back-to-back:
  - Stimulus: a `start` mid-frame, then `start` in the `done` cycle.
  - Required: the mid-frame `start` is ignored. The second frame begins at row 0 col 0 with one gap cycle.
- Reset mid-frame:
  - Stimulus: `rst` after 0x06 is output.
  - Required: next cycle IDLE, `out_valid`=0, `busy`=0.
  - After a new `start` with FWFT reloaded 0x00.., outputs restart at (0,0).
- Counter wrap at default 28×28:
  - Required: `out_col` wraps 27→0 with row increment, 784 pops total, `out_eof` only on pop 784.
